// File: rtl/updown_count_ctrl.sv
// Up/down counter with wrap/saturate boundaries and an LED flash burst on boundary crossings.
// Latency: count/led/bound_evt update on the edge that samples a pulse; pulses are dropped while busy.
module updown_count_ctrl #(
  parameter int WIDTH         = 4,
  parameter int FLASH_CYCLES  = 4,
  parameter int FLASH_TOGGLES = 3
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic             up_pulse,
  input  logic             down_pulse,
  input  logic             clr_pulse,
  input  logic             sat_mode,
  input  logic             step_sel,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] led,
  output logic             bound_evt,
  output logic             busy
);

  localparam int CW = $clog2(FLASH_CYCLES + 1);
  localparam int PW = $clog2(FLASH_TOGGLES + 1);
  localparam logic [CW-1:0]    CYC_LAST  = CW'(FLASH_CYCLES - 1);
  localparam logic [PW-1:0]    PAIR_LAST = PW'(FLASH_TOGGLES - 1);
  localparam logic [WIDTH-1:0] MAX       = '1;

  typedef enum logic [1:0] {IDLE, FLASH_ON, FLASH_OFF} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_led, w_led_nxt;
  logic             r_bound_evt, w_bound_nxt;
  logic [CW-1:0]    r_cyc, w_cyc_nxt;
  logic [PW-1:0]    r_pair, w_pair_nxt;

  logic [WIDTH:0]   w_step, w_sum, w_diff;
  logic             w_up, w_dn;

  // One extra bit catches the carry/borrow that marks a boundary crossing.
  assign w_step = (WIDTH+1)'(step_sel) + (WIDTH+1)'(1);
  assign w_sum  = {1'b0, r_count} + w_step;
  assign w_diff = {1'b0, r_count} - w_step;
  assign w_up   = up_pulse & ~down_pulse;
  assign w_dn   = down_pulse & ~up_pulse;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_led       <= '0;
      r_bound_evt <= 1'b0;
      r_cyc       <= '0;
      r_pair      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_led       <= w_led_nxt;
      r_bound_evt <= w_bound_nxt;
      r_cyc       <= w_cyc_nxt;
      r_pair      <= w_pair_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_led_nxt   = r_led;
    w_bound_nxt = 1'b0;
    w_cyc_nxt   = r_cyc;
    w_pair_nxt  = r_pair;

    if (clr_pulse) begin
      w_state_nxt = IDLE;
      w_count_nxt = '0;
      w_led_nxt   = '0;
      w_cyc_nxt   = '0;
      w_pair_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_up) begin
            w_count_nxt = w_sum[WIDTH-1:0];
            if (w_sum[WIDTH]) begin
              w_bound_nxt = 1'b1;
              if (sat_mode) w_count_nxt = MAX;
            end
          end else if (w_dn) begin
            w_count_nxt = w_diff[WIDTH-1:0];
            if (w_diff[WIDTH]) begin
              w_bound_nxt = 1'b1;
              if (sat_mode) w_count_nxt = '0;
            end
          end
          if (w_bound_nxt) begin
            w_state_nxt = FLASH_ON;
            w_led_nxt   = '1;
            w_cyc_nxt   = '0;
            w_pair_nxt  = '0;
          end else begin
            w_led_nxt = w_count_nxt;
          end
        end
        FLASH_ON: begin
          if (r_cyc == CYC_LAST) begin
            w_state_nxt = FLASH_OFF;
            w_led_nxt   = '0;
            w_cyc_nxt   = '0;
          end else begin
            w_cyc_nxt = r_cyc + CW'(1);
          end
        end
        FLASH_OFF: begin
          if (r_cyc == CYC_LAST) begin
            w_cyc_nxt = '0;
            if (r_pair == PAIR_LAST) begin
              w_state_nxt = IDLE;
              w_led_nxt   = r_count;
              w_pair_nxt  = '0;
            end else begin
              w_state_nxt = FLASH_ON;
              w_led_nxt   = '1;
              w_pair_nxt  = r_pair + PW'(1);
            end
          end else begin
            w_cyc_nxt = r_cyc + CW'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_led_nxt   = r_count;
          w_cyc_nxt   = '0;
          w_pair_nxt  = '0;
        end
      endcase
    end
  end

  assign count     = r_count;
  assign led       = r_led;
  assign bound_evt = r_bound_evt;
  assign busy      = (r_state != IDLE);

endmodule

// File: doc/updown_count_ctrl.md
UPDOWN_COUNT_CTRL -- requirements
Module: updown_count_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter and LED width in bits.
REQ-002 SHALL have parameter FLASH_CYCLES, default 4, clock cycles per LED flash half-period (short for simulation).
REQ-003 SHALL have parameter FLASH_TOGGLES, default 3, number of ON/OFF flash pairs per boundary event.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst_p  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port up_pulse  input  1  one-cycle increment request from the upstream debouncer.
REQ-007 SHALL have port down_pulse  input  1  one-cycle decrement request from the upstream debouncer.
REQ-008 SHALL have port clr_pulse  input  1  one-cycle clear request from the upstream debouncer.
REQ-009 SHALL have port sat_mode  input  1  level: 0 = wrap at boundaries, 1 = saturate.
REQ-010 SHALL have port step_sel  input  1  level: 0 = step 1, 1 = step 2.
REQ-011 SHALL have port count  output  WIDTH  current counter value, registered.
REQ-012 SHALL have port led  output  WIDTH  LED drive, registered.
REQ-013 SHALL have port bound_evt  output  1  one-cycle pulse on a boundary event.
REQ-014 SHALL have port busy  output  1  high while the flash sequence runs.

Function
REQ-015 SHALL implement states IDLE, FLASH_ON, FLASH_OFF.
REQ-016 SHALL sample inputs on each rising edge and update count on that same edge, so the new value is visible the cycle after the pulse.
REQ-017 SHALL give clr_pulse highest priority: count <= 0, state <= IDLE, flash aborted, bound_evt = 0, in any state.
REQ-018 SHALL treat up_pulse and down_pulse high together, without clr_pulse, as no operation: no count change, no event.
REQ-019 SHALL define step = 1 + step_sel and MAX = 2^WIDTH-1, computing next value in WIDTH+1 bits.
REQ-020 SHALL, on up with count+step > MAX: wrap mode gives (count+step) mod 2^WIDTH, saturate mode gives MAX; both raise a boundary event.
REQ-021 SHALL, on down with count < step: wrap mode gives (count-step) mod 2^WIDTH, saturate mode gives 0; both raise a boundary event.
REQ-022 SHALL NOT raise a boundary event when the result lands exactly on 0 or MAX without crossing.
REQ-023 SHALL, on a boundary event, assert bound_evt for exactly one cycle, registered together with the count update.
REQ-024 SHALL, on a boundary event in IDLE, enter FLASH_ON on the same edge.
REQ-025 SHALL drive led = all ones in FLASH_ON and led = 0 in FLASH_OFF; each state lasts FLASH_CYCLES cycles.
REQ-026 SHALL alternate FLASH_ON/FLASH_OFF for FLASH_TOGGLES pairs, then return to IDLE.
REQ-027 SHALL drive led = count in IDLE, with led updating on the same edge as count.
REQ-028 SHALL hold busy = 1 in FLASH_ON and FLASH_OFF and busy = 0 in IDLE.
REQ-029 SHALL ignore up_pulse and down_pulse while busy = 1: count unchanged, no bound_evt.
REQ-030 SHALL let sat_mode and step_sel changes take effect on the next accepted pulse only.

Reset
REQ-031 SHALL, while rst_p = 1, force count = 0, led = 0, bound_evt = 0, busy = 0, state = IDLE, and clear the flash counters, independent of clk.
REQ-032 SHALL, on rst_p asserted mid-flash, abort the flash immediately and resume IDLE operation on the first clock edge after deassertion.

Verification
REQ-033 SHALL cover: reset, then 3 up_pulse, step_sel = 0 -> count 1, 2, 3 one cycle after each pulse; led = count; bound_evt never high.
REQ-034 SHALL cover: wrap mode, count = 15, step_sel = 1, up_pulse -> count = 1, bound_evt high 1 cycle, busy high; led = F,0 alternating every 4 cycles for 3 pairs (24 cycles); then led = 1, busy = 0.
REQ-035 SHALL cover: saturate mode, count = 1, step_sel = 1, down_pulse -> count = 0, bound_evt pulse, flash starts; down_pulse during flash -> count stays 0, no new bound_evt.
REQ-036 SHALL cover: count = 5, up_pulse and down_pulse in the same cycle -> count = 5, no event; then count = 14, step 1, up -> 15, no event.
REQ-037 SHALL cover: clr_pulse during FLASH_OFF -> next cycle count = 0, led = 0, busy = 0, state IDLE.
REQ-038 SHALL cover: rst_p asserted mid-flash, between clock edges -> outputs 0 immediately; after release, up_pulse -> count = 1.
